// File: rtl/mux_add_arbiter_if.sv
// Bundle of requester-side and consumer-side signals for mux_add_arbiter.
// Optional out_carry is present only when MUX_ARB_CARRY_EN is defined.
interface mux_add_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  // Handshake: a transfer happens on a rising clk edge where valid & ready are
  // both 1. Producers hold their data and keep valid high until that edge;
  // ready may depend combinationally on valid, never the other way round.
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_a;
  logic [NUM_REQ*DW-1:0] req_b;
  logic [NUM_REQ-1:0]    req_s;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_w;
  logic [IDW-1:0]        out_id;
`ifdef MUX_ARB_CARRY_EN
  logic                  out_carry;
`endif
  // Debug visibility: output register FSM state (1 = FULL) and round-robin pointer
  logic                  state;
  logic [IDW-1:0]        rr_ptr;

`ifdef MUX_ARB_CARRY_EN
  modport master (output req_valid, req_a, req_b, req_s, out_ready,
                  input  req_ready, out_valid, out_w, out_id, out_carry, state, rr_ptr);
  modport slave  (input  req_valid, req_a, req_b, req_s, out_ready,
                  output req_ready, out_valid, out_w, out_id, out_carry, state, rr_ptr);
`else
  modport master (output req_valid, req_a, req_b, req_s, out_ready,
                  input  req_ready, out_valid, out_w, out_id, state, rr_ptr);
  modport slave  (input  req_valid, req_a, req_b, req_s, out_ready,
                  output req_ready, out_valid, out_w, out_id, state, rr_ptr);
`endif
endinterface

// File: rtl/mux_add_arbiter.sv
// Round-robin shared select-add unit (w = s ? b : a+b) with a registered result port.
// Define MUX_ARB_CARRY_EN to add the registered out_carry output.
module mux_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_add_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, grant_idx, scan_idx;
  logic           grant_found, accept_en, transfer;
  logic [DW-1:0]  sel_a, sel_b, res_w;
  logic           sel_s;
  logic [DW-1:0]  w_q;
  logic [IDW-1:0] id_q;

  // Scan offsets from the far end so the entry closest to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign accept_en = (state == EMPTY) || bus.out_ready;
  assign transfer  = rst_n && accept_en && grant_found;

  assign sel_a = bus.req_a[int'(grant_idx)*DW +: DW];
  assign sel_b = bus.req_b[int'(grant_idx)*DW +: DW];
  assign sel_s = bus.req_s[grant_idx];

`ifdef MUX_ARB_CARRY_EN
  logic [DW:0] sum;
  logic        res_c, c_q;
  assign sum   = {1'b0, sel_a} + {1'b0, sel_b};
  assign res_w = sel_s ? sel_b : sum[DW-1:0];
  assign res_c = sel_s ? 1'b0 : sum[DW];
`else
  assign res_w = sel_s ? sel_b : (sel_a + sel_b);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (transfer) state_nxt = FULL;
      FULL:    if (bus.out_ready && !transfer) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = '0;
    if (transfer) bus.req_ready[grant_idx] = 1'b1;
    bus.out_valid = (state == FULL);
    bus.state     = (state == FULL);
    bus.rr_ptr    = rr_ptr;
  end

  // Result register and pointer only move on a transfer; a drain alone leaves them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      id_q   <= '0;
      rr_ptr <= '0;
    end else if (transfer) begin
      w_q    <= res_w;
      id_q   <= grant_idx;
      rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  assign bus.out_w  = w_q;
  assign bus.out_id = id_q;

`ifdef MUX_ARB_CARRY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        c_q <= 1'b0;
    else if (transfer) c_q <= res_c;
  end
  assign bus.out_carry = c_q;
`endif
endmodule

// File: tb/tb_mux_add_arbiter.sv
// Directed bench for mux_add_arbiter: reference grant/result model feeding an expected queue.
// Build with MUX_ARB_CARRY_EN defined to also check out_carry.
module tb_mux_add_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DW      = 8;
  localparam int IDW     = 2;
  localparam int W       = IDW + DW + 1;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux_add_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();
  mux_add_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [DW-1:0]      a_v [NUM_REQ];
  logic [DW-1:0]      b_v [NUM_REQ];
  logic [NUM_REQ-1:0] s_v;
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
    assign bus.req_a[i*DW +: DW] = a_v[i];
    assign bus.req_b[i*DW +: DW] = b_v[i];
  end
  assign bus.req_s = s_v;

  // scoreboard: {carry, id, w}
  logic [W-1:0] exp_q[$];
  int  errors = 0;
  int  checks = 0;
  bit  m_full = 1'b0;
  int  m_ptr  = 0;
  bit  auto_clear = 1'b1;
  logic [DW-1:0]  held_w;
  logic [IDW-1:0] held_id;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW:0] model_res(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic s);
    if (s) return {1'b0, b};
    return {1'b0, a} + {1'b0, b};
  endfunction

  // One clock cycle: check grant, push expected result, then check the output register.
  task automatic step(input string tag);
    int g;
    bit xfer;
    logic [NUM_REQ-1:0] exp_ready;
    logic [DW:0] r;
    logic [W-1:0] e;
    #1;
    g = -1;
    for (int k = 0; k < NUM_REQ; k++) begin
      int i;
      i = (m_ptr + k) % NUM_REQ;
      if (g < 0 && bus.req_valid[i]) g = i;
    end
    xfer = (g >= 0) && (!m_full || bus.out_ready);
    exp_ready = xfer ? (NUM_REQ'(1) << g) : '0;
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'(exp_ready));
    if (m_full && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (xfer) begin
      r = model_res(a_v[g], b_v[g], s_v[g]);
      e = {r[DW], IDW'(g), r[DW-1:0]};
      exp_q.push_back(e);
    end
    @(posedge clk);
    m_full = xfer || (m_full && !bus.out_ready);
    if (xfer) m_ptr = (g + 1) % NUM_REQ;
    #1;
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(m_full));
    if (m_full && exp_q.size() > 0) begin
      e = exp_q[0];
      chk({tag, " out_w"},  32'(bus.out_w),  32'(e[DW-1:0]));
      chk({tag, " out_id"}, 32'(bus.out_id), 32'(e[DW+IDW-1:DW]));
`ifdef MUX_ARB_CARRY_EN
      chk({tag, " out_carry"}, 32'(bus.out_carry), 32'(e[W-1]));
`endif
    end
    if (xfer && auto_clear) bus.req_valid[g] = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    bus.req_valid = '1;
    m_full = 1'b0;
    m_ptr  = 0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, " out_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, " out_w"},     32'(bus.out_w),     32'h0);
    chk({tag, " out_id"},    32'(bus.out_id),    32'h0);
`ifdef MUX_ARB_CARRY_EN
    chk({tag, " out_carry"}, 32'(bus.out_carry), 32'h0);
`endif
    rst_n = 1'b1;
    bus.req_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_v[i] = '0;
      b_v[i] = '0;
    end
    s_v = '0;
    bus.out_ready = 1'b1;
    bus.req_valid = '0;

    // reset with all requesters valid
    do_reset("reset");

    // single op on requester 2, add then select
    a_v[2] = 8'h30; b_v[2] = 8'h12; s_v[2] = 1'b0;
    bus.req_valid = 4'b0100;
    step("single_add");
    chk("single_add w42", 32'(bus.out_w), 32'h42);
    chk("single_add id2", 32'(bus.out_id), 32'h2);
    s_v[2] = 1'b1;
    bus.req_valid = 4'b0100;
    step("single_sel");
    chk("single_sel w12", 32'(bus.out_w), 32'h12);
    step("drain");
    chk("drain empty", 32'(bus.out_valid), 32'h0);

    // overflow drops the carry from w
    a_v[1] = 8'hF0; b_v[1] = 8'h20; s_v[1] = 1'b0;
    bus.req_valid = 4'b0010;
    step("overflow");
    chk("overflow w10", 32'(bus.out_w), 32'h10);
`ifdef MUX_ARB_CARRY_EN
    chk("overflow carry1", 32'(bus.out_carry), 32'h1);
`endif

    // reset mid-stream
    for (int i = 0; i < NUM_REQ; i++) begin
      a_v[i] = 8'(8'h11 * (i + 1)); b_v[i] = 8'(8'h05 + i); s_v[i] = 1'b0;
    end
    bus.req_valid = 4'hF;
    step("pre_reset");
    rst_n = 1'b0;
    #1;
    chk("midreset out_valid", 32'(bus.out_valid), 32'h0);
    chk("midreset req_ready", 32'(bus.req_ready), 32'h0);
    m_full = 1'b0; m_ptr = 0; exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 4'hF;
    step("post_reset");
    chk("post_reset id0", 32'(bus.out_id), 32'h0);

    // rotation with all valid, no bubbles
    do_reset("reset2");
    auto_clear = 1'b0;
    s_v = 4'b1010;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_v[i] = 8'($urandom_range(0, 255)); b_v[i] = 8'($urandom_range(0, 255));
    end
    bus.req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      step("rotate");
      chk("rotate id_seq", 32'(bus.out_id), 32'(k % NUM_REQ));
      chk("rotate no_bubble", 32'(bus.out_valid), 32'h1);
    end

    // backpressure holds the register and blocks grants
    bus.out_ready = 1'b0;
    held_w  = bus.out_w;
    held_id = bus.out_id;
    for (int k = 0; k < 3; k++) begin
      step("stall");
      chk("stall w_stable",  32'(bus.out_w),  32'(held_w));
      chk("stall id_stable", 32'(bus.out_id), 32'(held_id));
    end
    bus.out_ready = 1'b1;
    step("refill");
    chk("refill id2", 32'(bus.out_id), 32'h2);

    // fairness skip from rr_ptr=1 over idle requesters
    auto_clear = 1'b1;
    bus.req_valid = '0;
    step("drain2");
    bus.req_valid = 4'b0001;
    step("set_ptr1");
    chk("set_ptr1 rr_ptr", 32'(bus.rr_ptr), 32'h1);
    bus.req_valid = 4'b1001;
    #1;
    chk("skip ready3", 32'(bus.req_ready), 32'h8);
    step("skip_g3");
    chk("skip id3", 32'(bus.out_id), 32'h3);
    chk("skip ptr0", 32'(bus.rr_ptr), 32'h0);
    step("skip_g0");
    chk("skip id0", 32'(bus.out_id), 32'h0);
    step("idle");
    chk("idle ptr_hold", 32'(bus.rr_ptr), 32'h1);
    step("idle2");
    chk("idle2 ptr_hold", 32'(bus.rr_ptr), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
